voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
- Upstream stage of the 4-bit PWM audio output; sits between the sound generator and pwm4bit.
- On each sample strobe, latches the four 4-bit voice levels and sums the enabled voices serially, one voice per clock.
- Scales the sum by a click-free ramped master gain, saturates to 4 bits, and presents the result to the PWM stage.
- Also produces a clip flag and a decaying peak level for the VGA overlay.

Parameters:
- SAMPLE_W, 4, width of each voice input and of the mixed output.
- GAIN_W, 3, master gain width; gain range 0..7; gain 4 gives the average of four voices.
- PEAK_DECAY, 1024, number of output samples per 1-step peak decrement.

Ports:
- clock  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-low reset; the block is reset while low.
- sample_ena  input  1  one-clock strobe at the sample rate.
- s1  input  SAMPLE_W  voice 0 level.
- s2  input  SAMPLE_W  voice 1 level.
- s3  input  SAMPLE_W  voice 2 level.
- s4  input  SAMPLE_W  voice 3 level.
- voice_mask  input  4  per-voice enable; bit i gates voice i (bit0 = s1).
- gain  input  GAIN_W  target master gain.
- sample  output  SAMPLE_W  mixed sample, held between updates.
- sample_valid  output  1  one-clock pulse when sample updates.
- busy  output  1  mix in progress.
- clip  output  1  last output sample was saturated.
- peak  output  SAMPLE_W  peak meter level.

Behaviour:
- Reset (reset low, async):
  - FSM in IDLE; accumulator and voice latches cleared.
  - cur_gain = 0, decay counter = 0.
  - All outputs 0: sample, sample_valid, busy, clip, peak.
- FSM states: IDLE, ACC (4 cycles, index 0..3), SCALE (1 cycle), OUT (1 cycle), then back to IDLE.
- Cycle t, IDLE with sample_ena=1:
  - Latch s1..s4 and voice_mask; clear accumulator (6 bits, max 60).
  - Inputs need only be stable in cycle t.
- Cycles t+1..t+4 (ACC): acc += latched voice[index] if its mask bit is set, else += 0.
- Cycle t+5 (SCALE):
  - prod = acc * cur_gain (9 bits); scaled = prod >> 4, truncating.
  - If scaled > 15: result = 15 and sat = 1; else sat = 0.
- Cycle t+6 (OUT), all registered, visible at t+6:
  - sample = result; sample_valid = 1 for this cycle only; clip = sat (held until the next OUT).
  - cur_gain steps one toward gain (+1 if below, -1 if above). SCALE always uses the pre-step cur_gain.
- busy = 1 in cycles t+1..t+6; 0 in IDLE.
- sample_ena while busy is dropped: no queueing, no effect. The sample period (≈3000 clocks) makes this a fault condition only.
- Peak meter, updated in OUT only:
  - If new sample >= peak: peak = sample, decay counter = 0.
  - Else counter += 1; at PEAK_DECAY-1, peak -= 1 (floor 0) and counter = 0.
- gain and voice_mask changes mid-mix:
  - gain is sampled only in OUT (ramp target).
  - voice_mask is sampled only at the strobe.
- Reset asserted mid-operation aborts the mix: no sample_valid, all state returns to reset values.

Decomposition:
- Shared audio package holds:
  - constants SAMPLE_W=4, ACC_W=6, GAIN_W=3, SCALE_SHIFT=4;
  - the FSM state enum (IDLE, ACC, SCALE, OUT).
- One natural sub-module, peak_meter:
  - ports: clock, reset, upd strobe, sample in, peak out;
  - parameter: PEAK_DECAY.

Test Plan:
- Reset and gain ramp:
  - Reset low: all outputs 0.
  - Release with gain=4, all voices 15, mask=1111, repeated strobes.
  - Expect samples 0, 3, 7, 11, 15, then 15 steady; clip=0 throughout.
- Latency and handshake: strobe at cycle t.
  - busy high exactly t+1..t+6.
  - sample_valid high only at t+6.
  - A second strobe at t+3 produces no extra sample_valid.
- Masking at steady gain=4 with s1=15, s2=8, s3=4, s4=2:
  - mask=1111 -> sample 7.
  - mask=0001 -> 3.
  - mask=0000 -> 0.
- Saturation at steady gain=7:
  - all voices 15 -> sample 15, clip=1.
  - all voices 8 -> sample 14, clip=0.
  - gain lowered 7->4 steps 6, 5, 4 over three samples.
- Peak decay with PEAK_DECAY=4: one sample of 15, then samples of 0.
  - peak=15 held.
  - peak decrements by 1 every 4 output samples, reaching 0 and staying 0.
- Reset mid-mix: reset pulsed low during ACC.
  - No sample_valid; sample, peak and cur_gain return to 0.
  - The next strobe after release completes normally.

Source files
------------

// File: rtl/voice_mixer_pkg.sv
// Shared audio constants and the mixer FSM state encoding.
// Combinational definitions only, so there is no latency.
// There is no flow control here; this file holds types only.
package voice_mixer_pkg;

  localparam int SAMPLE_W    = 4;
  localparam int ACC_W       = 6;   // four 4-bit voices sum to at most 60
  localparam int GAIN_W      = 3;
  localparam int SCALE_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } mix_state_e;

endpackage

// File: rtl/voice_mixer_peak_meter.sv
// Peak level follower with slow linear decay, for the VGA overlay meter.
// Latency: peak reflects an update one clock after the upd_i strobe.
// No backpressure: every upd_i strobe is consumed.
module voice_mixer_peak_meter #(
  parameter int SAMPLE_W   = 4,
  parameter int PEAK_DECAY = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                upd_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-1:0] peak_o
);

  localparam int CNT_W = (PEAK_DECAY > 1) ? $clog2(PEAK_DECAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PEAK_DECAY - 1);

  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Next peak: jump up to any louder sample, otherwise fall one step per PEAK_DECAY samples.
  always_comb begin
    peak_d = peak_q;
    cnt_d  = cnt_q;
    if (upd_i) begin
      if (sample_i >= peak_q) begin
        peak_d = sample_i;
        cnt_d  = '0;
      end else if (cnt_q == CNT_LAST) begin
        // sample_i < peak_q here, so peak_q is at least 1; the guard is kept for clarity
        if (peak_q != '0) begin
          peak_d = peak_q - SAMPLE_W'(1);
        end
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Peak and decay counter state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
      cnt_q  <= '0;
    end else begin
      peak_q <= peak_d;
      cnt_q  <= cnt_d;
    end
  end

  assign peak_o = peak_q;

endmodule

// File: rtl/voice_mixer.sv
// Serial four-voice mixer with ramped master gain and saturation, feeding pwm4bit.
// Latency: a strobe in cycle t yields sample_valid in cycle t+6; busy is high for t+1..t+6.
// No backpressure: a strobe that arrives while busy is dropped.
module voice_mixer #(
  parameter int SAMPLE_W   = voice_mixer_pkg::SAMPLE_W,
  parameter int GAIN_W     = voice_mixer_pkg::GAIN_W,
  parameter int PEAK_DECAY = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_ena,
  input  logic [SAMPLE_W-1:0] s1,
  input  logic [SAMPLE_W-1:0] s2,
  input  logic [SAMPLE_W-1:0] s3,
  input  logic [SAMPLE_W-1:0] s4,
  input  logic [3:0]          voice_mask,
  input  logic [GAIN_W-1:0]   gain,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy,
  output logic                clip,
  output logic [SAMPLE_W-1:0] peak
);

  import voice_mixer_pkg::*;

  localparam int PROD_W   = ACC_W + GAIN_W;
  localparam int SCALED_W = PROD_W - SCALE_SHIFT;
  localparam logic [SCALED_W-1:0] SAMPLE_MAX = SCALED_W'((1 << SAMPLE_W) - 1);

  mix_state_e                    state_q, state_d;
  logic [1:0]                    idx_q, idx_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic [3:0][SAMPLE_W-1:0]      voice_q, voice_d;
  logic [3:0]                    mask_q, mask_d;
  logic [GAIN_W-1:0]             cur_gain_q, cur_gain_d;
  logic [SAMPLE_W-1:0]           sample_q, sample_d;
  logic                          valid_q, valid_d;
  logic                          clip_q, clip_d;

  logic [ACC_W-1:0]              addend;
  logic [PROD_W-1:0]             prod;
  logic [SCALED_W-1:0]           scaled;
  logic                          sat;
  logic [SAMPLE_W-1:0]           result;

  // Datapath for the current voice and for the gain scaling of the finished sum.
  always_comb begin
    addend = mask_q[idx_q] ? ACC_W'(voice_q[idx_q]) : '0;
    prod   = PROD_W'(acc_q) * PROD_W'(cur_gain_q);
    scaled = SCALED_W'(prod >> SCALE_SHIFT);
    sat    = (scaled > SAMPLE_MAX);
    result = sat ? '1 : scaled[SAMPLE_W-1:0];
  end

  // Mix sequencer: latch on strobe, accumulate one voice per clock, scale, publish, ramp gain.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    voice_d    = voice_q;
    mask_d     = mask_q;
    cur_gain_d = cur_gain_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    clip_d     = clip_q;
    case (state_q)
      IDLE: begin
        if (sample_ena) begin
          voice_d = {s4, s3, s2, s1};
          mask_d  = voice_mask;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + addend;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        // Registered here so the sample is visible during the OUT cycle.
        sample_d = result;
        clip_d   = sat;
        valid_d  = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        // One gain step per sample keeps volume changes click-free.
        if (cur_gain_q < gain) begin
          cur_gain_d = cur_gain_q + GAIN_W'(1);
        end else if (cur_gain_q > gain) begin
          cur_gain_d = cur_gain_q - GAIN_W'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any mix in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      voice_q    <= '0;
      mask_q     <= '0;
      cur_gain_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      voice_q    <= voice_d;
      mask_q     <= mask_d;
      cur_gain_q <= cur_gain_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      clip_q     <= clip_d;
    end
  end

  voice_mixer_peak_meter #(
    .SAMPLE_W   (SAMPLE_W),
    .PEAK_DECAY (PEAK_DECAY)
  ) u_peak (
    .clock    (clock),
    .reset    (reset),
    .upd_i    (state_q == OUT),
    .sample_i (sample_q),
    .peak_o   (peak)
  );

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign clip         = clip_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer with a short peak decay.
// Inputs are driven and outputs sampled on the falling clock edge.
// The DUT has no backpressure; each mix is waited for with a cycle bound.
module tb_voice_mixer;

  logic       clock = 1'b0;
  logic       reset;
  logic       sample_ena;
  logic [3:0] s1, s2, s3, s4;
  logic [3:0] voice_mask;
  logic [2:0] gain;
  logic [3:0] sample;
  logic       sample_valid;
  logic       busy;
  logic       clip;
  logic [3:0] peak;

  int n_chk = 0;
  int n_bad = 0;

  logic [3:0] smp;
  logic       clp;

  always #10 clock = ~clock;

  voice_mixer #(
    .SAMPLE_W   (4),
    .GAIN_W     (3),
    .PEAK_DECAY (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_ena   (sample_ena),
    .s1           (s1),
    .s2           (s2),
    .s3           (s3),
    .s4           (s4),
    .voice_mask   (voice_mask),
    .gain         (gain),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .clip         (clip),
    .peak         (peak)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One full mix: strobe, scrub the inputs, wait (bounded) for the output pulse, return at t+7.
  task automatic do_mix(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] m,
                        output logic [3:0] o_smp, output logic o_clp);
    bit got = 1'b0;
    o_smp = '0;
    o_clp = 1'b0;
    @(negedge clock);
    s1 = a; s2 = b; s3 = c; s4 = d; voice_mask = m; sample_ena = 1'b1;
    @(negedge clock);
    sample_ena = 1'b0;
    s1 = '0; s2 = '0; s3 = '0; s4 = '0; voice_mask = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (sample_valid) begin
        got   = 1'b1;
        o_smp = sample;
        o_clp = clip;
      end else begin
        @(negedge clock);
      end
    end
    if (!got) check_eq("mix_timeout", 16'd0, 16'd1);
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ramp_exp[6] = '{0, 3, 7, 11, 15, 15};
    int down_smp[5] = '{14, 12, 10, 8, 8};
    int down_gain[5] = '{6, 5, 4, 4, 4};
    int pk;
    int pulses;

    reset = 1'b0; sample_ena = 1'b0;
    s1 = '0; s2 = '0; s3 = '0; s4 = '0; voice_mask = '0; gain = '0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_sample", 16'(sample), 16'd0);
    check_eq("rst_valid", 16'(sample_valid), 16'd0);
    check_eq("rst_busy", 16'(busy), 16'd0);
    check_eq("rst_clip", 16'(clip), 16'd0);
    check_eq("rst_peak", 16'(peak), 16'd0);
    gain = 3'd4;
    reset = 1'b1;
    @(negedge clock);

    // Gain ramp 0 -> 4 with every voice at full scale
    for (int i = 0; i < 6; i++) begin
      do_mix(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, smp, clp);
      check_eq($sformatf("ramp_sample%0d", i), 16'(smp), 16'(ramp_exp[i]));
      check_eq($sformatf("ramp_clip%0d", i), 16'(clp), 16'd0);
    end

    // Latency/handshake with a dropped strobe at t+3
    @(negedge clock);
    check_eq("lat_busy0", 16'(busy), 16'd0);
    s1 = 4'd15; s2 = 4'd15; s3 = 4'd15; s4 = 4'd15; voice_mask = 4'b1111; sample_ena = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      check_eq($sformatf("lat_busy%0d", k), 16'(busy), 16'((k >= 1 && k <= 6) ? 1 : 0));
      check_eq($sformatf("lat_valid%0d", k), 16'(sample_valid), 16'((k == 6) ? 1 : 0));
      if (k == 1) sample_ena = 1'b0;
      if (k == 3) sample_ena = 1'b1;
      if (k == 4) sample_ena = 1'b0;
    end

    // Masking at gain 4 with voices 15, 8, 4, 2
    do_mix(4'd15, 4'd8, 4'd4, 4'd2, 4'b1111, smp, clp);
    check_eq("mask_1111", 16'(smp), 16'd7);
    do_mix(4'd15, 4'd8, 4'd4, 4'd2, 4'b0001, smp, clp);
    check_eq("mask_0001", 16'(smp), 16'd3);
    do_mix(4'd15, 4'd8, 4'd4, 4'd2, 4'b0000, smp, clp);
    check_eq("mask_0000", 16'(smp), 16'd0);

    // Saturation at gain 7 (three mixes to ramp 4 -> 7 first)
    gain = 3'd7;
    for (int i = 0; i < 3; i++) do_mix(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, smp, clp);
    check_eq("gain_at7", 16'(dut.cur_gain_q), 16'd7);
    do_mix(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, smp, clp);
    check_eq("sat_sample", 16'(smp), 16'd15);
    check_eq("sat_clip", 16'(clp), 16'd1);
    check_eq("clip_hold", 16'(clip), 16'd1);
    do_mix(4'd8, 4'd8, 4'd8, 4'd8, 4'b1111, smp, clp);
    check_eq("g7_8s_sample", 16'(smp), 16'd14);
    check_eq("g7_8s_clip", 16'(clp), 16'd0);

    // Gain lowered 7 -> 4: one step per sample
    gain = 3'd4;
    for (int i = 0; i < 5; i++) begin
      do_mix(4'd8, 4'd8, 4'd8, 4'd8, 4'b1111, smp, clp);
      check_eq($sformatf("down_sample%0d", i), 16'(smp), 16'(down_smp[i]));
      check_eq($sformatf("down_gain%0d", i), 16'(dut.cur_gain_q), 16'(down_gain[i]));
    end

    // Peak hold and decay (PEAK_DECAY = 4)
    do_mix(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, smp, clp);
    check_eq("peak_top", 16'(peak), 16'd15);
    for (int k = 1; k <= 64; k++) begin
      do_mix(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, smp, clp);
      pk = 15 - (k / 4);
      if (pk < 0) pk = 0;
      check_eq($sformatf("peak_decay%0d", k), 16'(peak), 16'(pk));
    end

    // Reset pulsed during ACC
    do_mix(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, smp, clp);
    check_eq("pre_rst_sample", 16'(smp), 16'd15);
    @(negedge clock);
    s1 = 4'd15; s2 = 4'd15; s3 = 4'd15; s4 = 4'd15; voice_mask = 4'b1111; sample_ena = 1'b1;
    @(negedge clock);
    sample_ena = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", 16'(busy), 16'd0);
    check_eq("mid_rst_sample", 16'(sample), 16'd0);
    check_eq("mid_rst_peak", 16'(peak), 16'd0);
    check_eq("mid_rst_gain", 16'(dut.cur_gain_q), 16'd0);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (sample_valid) pulses++;
    end
    check_eq("mid_rst_no_valid", 16'(pulses), 16'd0);
    do_mix(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, smp, clp);
    check_eq("post_rst_sample0", 16'(smp), 16'd0);
    do_mix(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, smp, clp);
    check_eq("post_rst_sample1", 16'(smp), 16'd3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
